// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Power-on / reset controller. Qualifies the PLL lock flags, debounces the
//   board reset button, accepts a software reset request and releases the
//   reset domains one after another. Any lock loss, button press or software
//   request while releasing or running puts every domain back into reset for
//   a fixed hold period before lock qualification starts again.
//
// Ports
//   clk_i            free-running board clock
//   reset_i          synchronous active-high reset
//   lock_i           PLL lock flags (asynchronous, synchronised here)
//   button_n_i       board reset button, active-low (asynchronous, debounced)
//   sw_reset_i       single-cycle synchronous software reset request
//   reset_n_o        active-low domain resets, bit 0 released first
//   ready_o          high only while all domains are running
//   state_o          0 WAIT_LOCK, 1 RELEASE, 2 RUN, 3 HOLD
//   lock_loss_cnt_o  saturating count of lock-loss aborts
module reset_sequencer #(
    parameter int NUM_LOCKS       = 2,
    parameter int NUM_STAGES      = 3,
    parameter int STAGE_DELAY     = 16,
    parameter int LOCK_FILTER     = 64,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [NUM_LOCKS-1:0]  lock_i,
    input  logic                  button_n_i,
    input  logic                  sw_reset_i,
    output logic [NUM_STAGES-1:0] reset_n_o,
    output logic                  ready_o,
    output logic [1:0]            state_o,
    output logic [7:0]            lock_loss_cnt_o
);

    // One counter serves the lock filter, the stage delay and the hold time.
    localparam int CNT_MAX = (LOCK_FILTER > STAGE_DELAY) ? LOCK_FILTER : STAGE_DELAY;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(STAGE_DELAY - 1);
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2,
        HOLD      = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and button debounce
    // ------------------------------------------------------------------
    logic [NUM_LOCKS-1:0] lock_meta;
    logic [NUM_LOCKS-1:0] lock_sync;
    logic                 button_meta;
    logic                 button_sync;
    logic                 button_level;
    logic [DB_W-1:0]      db_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lock_meta    <= '0;
            lock_sync    <= '0;
            button_meta  <= 1'b0;
            button_sync  <= 1'b0;
            button_level <= 1'b1;
            db_cnt       <= '0;
        end else begin
            lock_meta   <= lock_i;
            lock_sync   <= lock_meta;
            button_meta <= button_n_i;
            button_sync <= button_meta;
            // The level flips on the edge that sees the DEBOUNCE_CYCLES-th
            // consecutive differing sample.
            if (button_sync == button_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                button_level <= button_sync;
                db_cnt       <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    logic locks_ok;
    logic pressed;
    logic abort;

    assign locks_ok = &lock_sync;
    assign pressed  = ~button_level;
    assign abort    = ~locks_ok | pressed | sw_reset_i;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;
    logic [NUM_STAGES-1:0] rst_n_d;
    logic                  ready_d;
    logic [7:0]            loss_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= WAIT_LOCK;
            cnt_q           <= '0;
            idx_q           <= '0;
            reset_n_o       <= '0;
            ready_o         <= 1'b0;
            lock_loss_cnt_o <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            reset_n_o       <= rst_n_d;
            ready_o         <= ready_d;
            lock_loss_cnt_o <= loss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_n_d = reset_n_o;
        loss_d  = lock_loss_cnt_o;

        case (state_q)
            WAIT_LOCK: begin
                rst_n_d = '0;
                if (locks_ok && !pressed && !sw_reset_i) begin
                    if (cnt_q == FILTER_LAST) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            RELEASE, RUN: begin
                if (state_q == RUN) begin
                    rst_n_d = '1;
                end
                // Abort is checked first so that it beats a coinciding
                // stage release.
                if (abort) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    rst_n_d = '0;
                    if (!locks_ok && lock_loss_cnt_o != 8'hFF) begin
                        loss_d = lock_loss_cnt_o + 8'd1;
                    end
                end else if (state_q == RELEASE) begin
                    if (cnt_q == DELAY_LAST) begin
                        cnt_d = '0;
                        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                            if (k == 32'(idx_q)) begin
                                rst_n_d[k] = 1'b1;
                            end
                        end
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            HOLD: begin
                rst_n_d = '0;
                if (cnt_q == DELAY_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
                rst_n_d = '0;
            end
        endcase

        ready_d = (state_d == RUN);
    end

    assign state_o = state_q;

endmodule
